// File: rtl/division_unit_pkg.sv
// Shared constants for the iterative divider: default width and FSM encoding.
// No logic lives here.
package division_unit_pkg;

    localparam int DIV_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/division_unit_restoring_step.sv
// One restoring-division step: shift in the next dividend bit and trial-subtract the divisor.
// Combinational (0 cycles); no handshake. full_adder is the one-bit cell the subtractor ripples through.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);
    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module restoring_step #(
    parameter int l = 16
) (
    input  logic [l-1:0] rem_i,
    input  logic         bit_i,
    input  logic [l-1:0] div_i,
    output logic [l-1:0] rem_o,
    output logic         q_o
);
    logic [l:0] shifted;
    logic [l:0] sub_b;
    logic [l:0] diff;
    logic [l:0] carry;

    assign shifted  = {rem_i, bit_i};
    assign sub_b    = ~{1'b0, div_i};
    assign carry[0] = 1'b1;

    // The top bit only needs the sum; its carry-out carries no extra information.
    for (genvar i = 0; i < l; i++) begin : g_sub
        full_adder u_fa (
            .a_i    (shifted[i]),
            .b_i    (sub_b[i]),
            .cin_i  (carry[i]),
            .s_o    (diff[i]),
            .cout_o (carry[i+1])
        );
    end
    assign diff[l] = shifted[l] ^ sub_b[l] ^ carry[l];

    // Both candidates are below the divisor, so l bits always hold the new remainder.
    assign q_o   = ~diff[l];
    assign rem_o = q_o ? diff[l-1:0] : shifted[l-1:0];
endmodule

// File: rtl/division_unit.sv
// Iterative unsigned restoring divider, one quotient bit per clock (l cycles; divide-by-zero in 1).
// start is ignored while busy; results hold until the next accepted start.
module division_unit
    import division_unit_pkg::*;
#(
    parameter int l = DIV_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [l-1:0] dividend,
    input  logic [l-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [l-1:0] quotient,
    output logic [l-1:0] remainder,
    output logic         div_by_zero
);
    localparam int CW = (l > 2) ? $clog2(l) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [l-1:0]  q_sh_q, q_sh_d;
    logic [l-1:0]  d_q, d_d;
    logic [l-1:0]  r_q, r_d;
    logic [l-1:0]  quot_q, quot_d;
    logic [l-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [l-1:0]  step_rem;
    logic          step_q;

    restoring_step #(.l(l)) u_step (
        .rem_i (r_q),
        .bit_i (q_sh_q[l-1]),
        .div_i (d_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            q_sh_q  <= '0;
            d_q     <= '0;
            r_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_sh_q  <= q_sh_d;
            d_q     <= d_d;
            r_q     <= r_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_sh_d  = q_sh_q;
        d_d     = d_q;
        r_d     = r_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        state_d = ST_FIN;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        q_sh_d  = dividend;
                        d_d     = divisor;
                        r_d     = '0;
                        cnt_d   = '0;
                        quot_d  = '0;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                r_d    = step_rem;
                q_sh_d = {q_sh_q[l-2:0], step_q};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(l - 1)) begin
                    quot_d  = {q_sh_q[l-2:0], step_q};
                    rem_d   = step_rem;
                    state_d = ST_FIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_FIN);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: doc/division_unit.md
Name: division_unit

Overview:
- Iterative unsigned integer divider for the ALU, built as the inverse of the combinational multiplier.
- Uses a restoring shift/subtract algorithm and produces one quotient bit per clock.
- Returns the quotient and the remainder. Divide-by-zero follows RISC-V semantics.
- Signed division is handled by the ALU wrapper, which applies sign fix-up around this block.

Parameters:
- l, 16, operand/result width in bits (l ≥ 2)

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin a division; sampled only when busy=0
- dividend  input  l  numerator; captured on the accepting edge
- divisor  input  l  denominator; captured on the accepting edge
- busy  output  1  high while an operation is in progress; start is ignored while high
- done  output  1  one-cycle pulse when quotient/remainder become valid
- quotient  output  l  result quotient; held until the next accepted start
- remainder  output  l  result remainder; held until the next accepted start
- div_by_zero  output  1  set together with done when divisor was 0; held with the results

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Iteration counter=0.
  - Reset overrides start.
  - Reset mid-operation aborts the operation: no done pulse, outputs cleared.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - FIN: busy=0, done=1 for exactly one cycle.
- IDLE or FIN, start=1 and divisor≠0 at edge E0:
  - Capture dividend into the shift register Q and divisor into D.
  - Clear partial remainder R (l+1 bits) and counter.
  - Go to RUN.
  - quotient, remainder and div_by_zero clear to 0 at E0.
- IDLE or FIN, start=1 and divisor==0:
  - Go directly to FIN.
  - quotient=all ones (2^l−1), remainder=dividend, div_by_zero=1.
  - done is high the cycle after the accepting edge (latency 1).
- RUN, each edge:
  - T = {R[l-1:0], Q[l-1]} − {0,D}, computed in l+1 bits.
  - If T is non-negative (T[l]==0): R←T and shift 1 into Q LSB.
  - Otherwise: R←{R[l-1:0],Q[l-1]} and shift 0 into Q LSB.
  - Q shifts left by one; counter increments.
  - After the l-th step (edge El): load quotient←Q, remainder←R[l-1:0], go to FIN.
  - Total latency is l edges after E0; done is high in the cycle after El.
- FIN: the next edge returns to IDLE unless start=1.
  - start=1 in FIN is accepted exactly as in IDLE, so back-to-back operations cost l+1 cycles each.
  - done deasserts on that edge either way.
- start while busy=1 is ignored; the in-flight operands are unaffected.
- Operand inputs are don't-care except on the accepting edge.
- Invariants for every non-zero divisor:
  - dividend == quotient·divisor + remainder.
  - remainder < divisor.
  - No overflow is possible for unsigned operation.

Decomposition:
- Shared include file (alongside the adder include):
  - State encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_FIN=2'd2.
  - Default width constant (16).
- Sub-module restoring_step (combinational, parameter l):
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder and quotient bit.
  - Built from the existing one-bit Adder cells (ripple subtract via inverted divisor with Cin=1).
- The top module holds the FSM, counter and registers.

Test Plan:
- Basic: rst, then start with dividend=100, divisor=7 → busy for 16 cycles; done pulses once 16 edges after acceptance; quotient=14, remainder=2, div_by_zero=0.
- Divisor larger than dividend and max dividend:
  - 5/9 → quotient=0, remainder=5.
  - 0xFFFF/1 → quotient=0xFFFF, remainder=0.
  - 0xFFFF/0xFFFF → quotient=1, remainder=0.
- Divide by zero: 1234/0 → done the cycle after acceptance; quotient=0xFFFF, remainder=1234, div_by_zero=1; next normal op clears div_by_zero.
- Handshake:
  - Pulse start again during RUN with different operands → ignored; result still matches the first operands.
  - start asserted in the FIN cycle → new op accepted, no IDLE gap, second done 17 cycles after the first.
- Reset mid-op: assert rst at iteration 8 → next cycle busy=0, outputs 0, no done pulse; a subsequent 200/10 yields quotient=20, remainder=0.
- Randomised sweep (≥10k operand pairs) checked against the invariants plus a golden model; parameter l=8 regression included.
